// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one full-adder slice per clock,
// LSB first, with a registered carry. Produces result, carryout, overflow and
// zero with the same meaning as the combinational ripple add/sub chain.
module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;     // operand A, shifted right one bit per RUN edge
    logic [WIDTH-1:0] b_sr;     // operand B, shifted right one bit per RUN edge
    logic [WIDTH-1:0] sum_sr;   // sum bits enter at the MSB and move toward bit 0
    logic [CNT_W-1:0] cnt;      // index of the bit being added this cycle
    logic             sub_r;
    logic             c;        // carry into the current bit

    logic             bx;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    // One full-adder slice on the current LSBs; B is inverted for subtraction.
    // NOTE: every signal gets a value on every pass through always_comb so no latch is inferred.
    always_comb begin
        bx       = b_sr[0] ^ sub_r;
        s        = a_sr[0] ^ bx ^ c;
        c_next   = (a_sr[0] & bx) | (c & (a_sr[0] ^ bx));
        sum_next = {s, sum_sr[WIDTH-1:1]};
    end

    // Sequencer and datapath: capture on start, one bit per RUN edge, publish at the last bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            // NOTE: the shift registers are ordinary flops, not a RAM, so they are cleared like the rest.
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            cnt      <= '0;
            sub_r    <= 1'b0;
            c        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        sub_r <= sub;
                        c     <= sub;   // +1 completes the two's complement of B
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    c      <= c_next;
                    if (cnt == LAST_BIT) begin
                        // c is the carry into the MSB here, c_next the carry out of it.
                        result   <= sum_next;
                        carryout <= c_next;
                        overflow <= c ^ c_next;
                        zero     <= ~|sum_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed vectors with hand-computed results for the
// 32-bit bit-serial adder/subtractor, including latency, back-to-back, ignored
// start during RUN and reset in the middle of an operation.
module tb_serial_add_sub;

    localparam int WIDTH = 32;
    localparam int LIMIT = 100;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    int checks = 0;
    int failures = 0;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after an edge; presents an operation for the next edge.
    task automatic start_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                            input logic op_sub);
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the start edge (edge 1). Counts edges until done,
    // counts busy cycles, optionally pulses start at a given RUN cycle, and
    // checks that the published result holds until completion.
    task automatic wait_done(input string tag, input int glitch_at,
                             output int lat, output int busy_cnt);
        logic [WIDTH-1:0] held;
        logic             stable;
        held     = result;
        stable   = 1'b1;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < LIMIT) begin
            if (glitch_at > 0 && lat == glitch_at) begin
                a     = 32'hDEAD_BEEF;
                b     = 32'h0BAD_F00D;
                sub   = ~sub;
                start = 1'b1;
            end else if (glitch_at > 0 && lat == glitch_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (!done && result !== held) stable = 1'b0;
        end
        if (!done) check({tag, "_timeout"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, "_hold"}, 64'(stable), 64'd1);
    endtask

    task automatic check_res(input string tag, input int lat,
                             input logic [WIDTH-1:0] exp_r, input logic exp_c,
                             input logic exp_v, input logic exp_z);
        check({tag, "_lat"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, "_result"}, 64'(result), 64'(exp_r));
        check({tag, "_flags"}, {61'd0, carryout, overflow, zero}, {61'd0, exp_c, exp_v, exp_z});
    endtask

    initial begin
        int lat;
        int bc;

        // Reset: all outputs low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {62'd0, busy, done}, 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", {61'd0, carryout, overflow, zero}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x7FFFFFFF + 1: signed overflow, 33-edge latency, busy for 32 cycles.
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_busy_first", 64'(busy), 64'd1);
        wait_done("add_ovf", 0, lat, bc);
        check_res("add_ovf", lat, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        check("add_ovf_busy", 64'(bc), 64'(WIDTH));
        @(posedge clk);
        #1;
        check("add_ovf_pulse", {62'd0, busy, done}, 64'd0);
        check("idle_result_hold", 64'(result), 64'h8000_0000);

        // 5 - 5: zero with no borrow.
        start_op(32'd5, 32'd5, 1'b1);
        wait_done("sub_eq", 0, lat, bc);
        check_res("sub_eq", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // 0 - 1: borrow, no signed overflow.
        @(posedge clk);
        #1;
        start_op(32'd0, 32'd1, 1'b1);
        wait_done("sub_borrow", 0, lat, bc);
        check_res("sub_borrow", lat, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // 0xFFFFFFFF + 1: unsigned wrap to zero.
        @(posedge clk);
        #1;
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done("add_wrap", 0, lat, bc);
        check_res("add_wrap", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Start pulsed at RUN cycle 10 with other operands: ignored.
        @(posedge clk);
        #1;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_done("ignore", 10, lat, bc);
        check_res("ignore", lat, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        check("ignore_busy", 64'(bc), 64'(WIDTH));

        // Reset at RUN cycle 7: outputs clear, no done pulse.
        @(posedge clk);
        #1;
        start_op(32'hAAAA_5555, 32'h0F0F_0F0F, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midrst_ctrl", {62'd0, busy, done}, 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_flags", {61'd0, carryout, overflow, zero}, 64'd0);
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("midrst_no_done", {62'd0, busy, done}, 64'd0);

        // 0x80000000 - 1: signed overflow, no borrow.
        start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done("sub_ovf", 0, lat, bc);
        check_res("sub_ovf", lat, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Start held high across two operations: back-to-back, done 33 apart.
        @(posedge clk);
        #1;
        a     = 32'd3;
        b     = 32'd4;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done("b2b_1", 0, lat, bc);
        check_res("b2b_1", lat, 32'd7, 1'b0, 1'b0, 1'b0);
        a   = 32'd100;
        b   = 32'd1;
        sub = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_restart", {62'd0, busy, done}, 64'b10);
        start = 1'b0;
        wait_done("b2b_2", 0, lat, bc);
        check_res("b2b_2", lat, 32'd99, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("b2b_pulse", {62'd0, busy, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
